// File: rtl/latch_write_sequencer.sv
// Write sequencer for a bank of level-sensitive D latches on a shared data bus.
// Each accepted write runs setup, enable-pulse and hold phases around a stable D.
module latch_write_sequencer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned N_LATCH   = 4,
   parameter int unsigned ADDR_W    = 2,
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned HOLD_CYC  = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [WIDTH-1:0]   wr_data,
   output logic [WIDTH-1:0]   latch_D,
   output logic [N_LATCH-1:0] latch_E,
   output logic               done,
   output logic               err
);

   localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [WIDTH-1:0]   data_q;
   logic [N_LATCH-1:0] en_q, en_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               accept;
   logic               addr_ok;
   logic               load;

   assign accept  = wr_valid && (state_q == StIdle);
   assign addr_ok = 32'(wr_addr) < N_LATCH;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter is loaded with (phase length - 1) on entry and counts down to zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept && addr_ok) begin
               state_d = StSetup;
               cnt_d   = CNT_W'(SETUP_CYC - 1);
               load    = 1'b1;
            end
         end
         StSetup: begin
            if (cnt_q == '0) begin
               state_d = StPulse;
               cnt_d   = CNT_W'(PULSE_CYC - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StPulse: begin
            if (cnt_q == '0) begin
               state_d = StHold;
               cnt_d   = CNT_W'(HOLD_CYC - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Enables follow the next state so they are registered and aligned to the pulse phase.
   always_comb begin
      en_d   = (state_d == StPulse) ? (N_LATCH'(1) << addr_q) : '0;
      done_d = (state_q == StHold) && (cnt_q == '0);
      err_d  = accept && !addr_ok;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
         data_q <= '0;
         en_q   <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (load) begin
            addr_q <= wr_addr;
            data_q <= wr_data;
         end
         en_q   <= en_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign wr_ready = (state_q == StIdle);
   assign latch_D  = data_q;
   assign latch_E  = en_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Scoreboard bench: stimulus queues expected transactions, a negedge monitor checks
// per-cycle outputs against the queued record and retires it on done/err.
module tb_latch_write_sequencer;

   typedef struct {
      int         dut;
      bit         is_err;
      int         base;
      int         s;
      int         p;
      int         h;
      logic [3:0] oh;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   n_chk;
   int   n_fail;

   logic       clk;
   logic       reset_n;
   logic       valid [3];
   logic [1:0] addr  [3];
   logic [7:0] data  [3];

   logic       rdy0, rdy1, rdy2;
   logic [7:0] ld0, ld1, ld2;
   logic [3:0] le0, le2;
   logic [2:0] le1;
   logic       dn0, dn1, dn2;
   logic       er0, er1, er2;

   latch_write_sequencer u_dut0 (
      .clk(clk), .reset_n(reset_n), .wr_valid(valid[0]), .wr_ready(rdy0),
      .wr_addr(addr[0]), .wr_data(data[0]), .latch_D(ld0), .latch_E(le0),
      .done(dn0), .err(er0)
   );

   latch_write_sequencer #(.N_LATCH(3)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .wr_valid(valid[1]), .wr_ready(rdy1),
      .wr_addr(addr[1]), .wr_data(data[1]), .latch_D(ld1), .latch_E(le1),
      .done(dn1), .err(er1)
   );

   latch_write_sequencer #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .wr_valid(valid[2]), .wr_ready(rdy2),
      .wr_addr(addr[2]), .wr_data(data[2]), .latch_D(ld2), .latch_E(le2),
      .done(dn2), .err(er2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic mon(input int k, input logic rdy, input logic [7:0] ld, input logic [3:0] le,
                      input logic dn, input logic er);
      exp_t r;
      int   rel;
      int   tot;
      logic [3:0] le_exp;
      chk($sformatf("d%0d_onehot", k), 32'($countones(le) <= 1), 32'(1));
      if (sb.size() != 0 && sb[0].dut == k) begin
         r   = sb[0];
         rel = cyc - r.base;
         tot = r.s + r.p + r.h;
         if (rel < 1) begin
            chk($sformatf("d%0d_done_idle", k), 32'(dn), 32'(0));
            chk($sformatf("d%0d_err_idle", k), 32'(er), 32'(0));
         end else if (r.is_err) begin
            chk($sformatf("d%0d_err", k), 32'(er), 32'(1));
            chk($sformatf("d%0d_err_ready", k), 32'(rdy), 32'(1));
            chk($sformatf("d%0d_err_le", k), 32'(le), 32'(0));
            chk($sformatf("d%0d_err_ld", k), 32'(ld), 32'(r.data));
            chk($sformatf("d%0d_err_done", k), 32'(dn), 32'(0));
            void'(sb.pop_front());
         end else if (rel <= tot) begin
            le_exp = (rel > r.s && rel <= r.s + r.p) ? r.oh : 4'b0000;
            chk($sformatf("d%0d_busy_ready", k), 32'(rdy), 32'(0));
            chk($sformatf("d%0d_busy_ld", k), 32'(ld), 32'(r.data));
            chk($sformatf("d%0d_busy_le", k), 32'(le), 32'(le_exp));
            chk($sformatf("d%0d_busy_done", k), 32'(dn), 32'(0));
            chk($sformatf("d%0d_busy_err", k), 32'(er), 32'(0));
         end else begin
            chk($sformatf("d%0d_done", k), 32'(dn), 32'(1));
            chk($sformatf("d%0d_done_ready", k), 32'(rdy), 32'(1));
            chk($sformatf("d%0d_done_ld", k), 32'(ld), 32'(r.data));
            chk($sformatf("d%0d_done_le", k), 32'(le), 32'(0));
            void'(sb.pop_front());
         end
      end else begin
         chk($sformatf("d%0d_no_done", k), 32'(dn), 32'(0));
         chk($sformatf("d%0d_no_err", k), 32'(er), 32'(0));
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            mon(0, rdy0, ld0, le0, dn0, er0);
            mon(1, rdy1, ld1, {1'b0, le1}, dn1, er1);
            mon(2, rdy2, ld2, le2, dn2, er2);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic v, input logic [1:0] a, input logic [7:0] d);
      valid[k] = v;
      addr[k]  = a;
      data[k]  = d;
   endtask

   task automatic push(input int k, input bit is_err, input int base, input int s, input int p,
                       input int h, input logic [3:0] oh, input logic [7:0] d);
      exp_t r;
      r.dut    = k;
      r.is_err = is_err;
      r.base   = base;
      r.s      = s;
      r.p      = p;
      r.h      = h;
      r.oh     = oh;
      r.data   = d;
      sb.push_back(r);
   endtask

   int b;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) drive(k, 1'b0, 2'd0, 8'h00);
      repeat (2) step();
      chk("rst_ready", 32'(rdy0), 32'(1));
      chk("rst_ld", 32'(ld0), 32'(0));
      chk("rst_le", 32'(le0), 32'(0));
      chk("rst_done", 32'(dn0), 32'(0));
      chk("rst_err", 32'(er0), 32'(0));
      reset_n = 1'b1;
      step();

      // Single write then a back-to-back request held from cycle 1.
      b = cyc;
      push(0, 1'b0, b, 1, 2, 1, 4'b0100, 8'hA5);
      push(0, 1'b0, b + 5, 1, 2, 1, 4'b0001, 8'h3C);
      drive(0, 1'b1, 2'd2, 8'hA5);
      step();
      drive(0, 1'b1, 2'd0, 8'h3C);
      repeat (5) step();
      // Bus churn while busy must not reach latch_D.
      for (int i = 0; i < 5; i++) begin
         drive(0, 1'b0, 2'(i), (i % 2 == 0) ? 8'h55 : 8'hAA);
         step();
      end
      drive(0, 1'b0, 2'd0, 8'h00);
      repeat (2) step();

      // Out-of-range address on a 3-latch bank.
      b = cyc;
      push(1, 1'b0, b, 1, 2, 1, 4'b0100, 8'h5A);
      drive(1, 1'b1, 2'd2, 8'h5A);
      step();
      drive(1, 1'b0, 2'd0, 8'h00);
      repeat (5) step();
      b = cyc;
      push(1, 1'b1, b, 1, 2, 1, 4'b0000, 8'h5A);
      push(1, 1'b1, b + 1, 1, 2, 1, 4'b0000, 8'h5A);
      drive(1, 1'b1, 2'd3, 8'hEE);
      repeat (2) step();
      drive(1, 1'b0, 2'd0, 8'h00);
      repeat (3) step();

      // Reset in the middle of the enable pulse.
      b = cyc;
      push(0, 1'b0, b, 1, 2, 1, 4'b0100, 8'h77);
      drive(0, 1'b1, 2'd2, 8'h77);
      step();
      drive(0, 1'b0, 2'd0, 8'h00);
      step();
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_le", 32'(le0), 32'(0));
      chk("midrst_ld", 32'(ld0), 32'(0));
      chk("midrst_ready", 32'(rdy0), 32'(1));
      chk("midrst_done", 32'(dn0), 32'(0));
      repeat (2) step();
      reset_n = 1'b1;
      repeat (6) step();
      b = cyc;
      push(0, 1'b0, b, 1, 2, 1, 4'b0010, 8'hFF);
      drive(0, 1'b1, 2'd1, 8'hFF);
      step();
      drive(0, 1'b0, 2'd0, 8'h00);
      repeat (6) step();

      // Longer setup and hold, single-cycle pulse.
      b = cyc;
      push(2, 1'b0, b, 3, 1, 2, 4'b1000, 8'h81);
      drive(2, 1'b1, 2'd3, 8'h81);
      step();
      for (int i = 0; i < 7; i++) begin
         drive(2, 1'b0, 2'(i), (i % 2 == 0) ? 8'h7E : 8'h18);
         step();
      end
      drive(2, 1'b0, 2'd0, 8'h00);
      repeat (3) step();

      chk("sb_empty", 32'(sb.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/latch_write_sequencer.md
# latch_write_sequencer

Synchronous write controller that drives a bank of N_LATCH level-sensitive D latches sharing one data bus. It accepts a write request (address + data) over a valid/ready handshake. It then sequences the latch enables as setup, enable pulse and hold phases, so that data is stable around the whole enable window. This block is the driving end of the latch interface: it produces the D and E signals a D latch consumes. It sits between register-level control logic and the latch bank.

## Interface

- WIDTH, 8, data bus width
- N_LATCH, 4, number of latches in the bank (one enable line each)
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= N_LATCH
- SETUP_CYC, 1, cycles D is driven before enable rises (>= 1)
- PULSE_CYC, 2, cycles enable is held high (>= 1)
- HOLD_CYC, 1, cycles D is held after enable falls (>= 1)

- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  sequencer idle and able to accept
- wr_addr  in  ADDR_W  target latch index
- wr_data  in  WIDTH  value to store
- latch_D  out  WIDTH  shared data bus to all latches (registered)
- latch_E  out  N_LATCH  per-latch enable, at most one bit high (registered)
- done  out  1  one-cycle pulse: write completed
- err  out  1  one-cycle pulse: request rejected (address out of range)

## Operation

- States: IDLE, SETUP, PULSE, HOLD. A down-counter sized for max(SETUP_CYC, PULSE_CYC, HOLD_CYC) times each phase.
- wr_ready = (state == IDLE). A request is accepted on a rising edge where wr_valid && wr_ready.
- On accept with wr_addr < N_LATCH:
  - wr_addr is captured; wr_data is loaded into latch_D.
  - The state goes to SETUP.
- On accept with wr_addr >= N_LATCH:
  - err = 1 for the next cycle; the state stays IDLE.
  - latch_D and latch_E are unchanged. done is not asserted.
- SETUP: latch_E = 0, latch_D stable, for SETUP_CYC cycles, then PULSE.
- PULSE: latch_E = one-hot(captured addr), latch_D stable, for PULSE_CYC cycles, then HOLD.
- HOLD: latch_E = 0, latch_D stable, for HOLD_CYC cycles, then IDLE with done = 1 for exactly that first IDLE cycle.
- latch_D keeps its last value in IDLE until the next accepted request. It never changes while the state is SETUP, PULSE or HOLD.
- Changes on wr_data or wr_addr while the state is not IDLE have no effect.
- wr_valid while busy is ignored: there is no queueing, and the requester must hold its request.
- The done cycle is an IDLE cycle, so wr_ready = 1 there. A back-to-back request accepted on that edge starts SETUP in the following cycle.
- latch_E is driven from flops only; no combinational path from inputs to latch_E. This keeps the enables glitch-free.

## Timing

- Reset (reset_n low, asynchronous, immediate):
  - state = IDLE, latch_D = 0, latch_E = 0, done = 0, err = 0, wr_ready = 1.
  - Accepts are suppressed while reset_n is low.
- Number cycles n relative to the accept edge (cycle 1 = first cycle after it). Let S = SETUP_CYC, P = PULSE_CYC, H = HOLD_CYC.
  - latch_D = new data from cycle 1.
  - SETUP in cycles 1..S.
  - latch_E[addr] = 1 in cycles S+1..S+P.
  - HOLD in cycles S+P+1..S+P+H.
  - done = 1 and wr_ready = 1 in cycle S+P+H+1.
- Defaults: enable high in cycles 2–3, done in cycle 5. Minimum request-to-request spacing is S+P+H+1 cycles.
- err: asserted in cycle 1 after a rejected accept; wr_ready stays 1 throughout.
- Reset mid-operation:
  - latch_E drops to 0 asynchronously. This may truncate the enable pulse, which is accepted.
  - No done pulse is produced; the sequencer is in IDLE on release.

## Test plan

- Reset then single write, defaults: wr_addr = 2, wr_data = 0xA5 accepted at edge 0 -> latch_D = 0xA5 from cycle 1; latch_E = 4'b0100 in cycles 2–3 only; done = 1 in cycle 5 only; wr_ready = 0 in cycles 1–4.
- Back-to-back: second request (addr 0, data 0x3C) held valid from cycle 1 -> accepted on the done edge. latch_D must not change before cycle 6. latch_E = 4'b0001 in cycles 7–8. done in cycle 10.
- Out-of-range: N_LATCH = 3, wr_addr = 3 -> err = 1 in cycle 1; latch_E stays 0; latch_D unchanged; no done; wr_ready stays 1.
- Bus stability: toggle wr_data every cycle while busy -> latch_D constant through SETUP/PULSE/HOLD. latch_E never has more than one bit set at any cycle.
- Reset mid-pulse: assert reset_n = 0 in cycle 2 -> latch_E = 0 and latch_D = 0 immediately; no done. After release, a write with addr 1, data 0xFF completes normally.
- Parameter sweep: SETUP_CYC = 3, PULSE_CYC = 1, HOLD_CYC = 2 -> enable high in cycle 4 only; done in cycle 7.
